power_charge: RTL and testbench
===============================

# power_charge

Local shot-power generator; the producing end of the power value that speed computation consumes. While it is the local player's turn, holding the fire button ramps `power` at a fixed tick rate; releasing it latches the value, pulses `fire`, and hands a one-byte power frame to the inter-board link transmitter, so the remote board receives it as its `in_power`. Sits between the debounced button input and the UART TX / trajectory logic.

## Interface
- `TICK_DIV`, 6_000_000: clock cycles per power step (100 ms at 60 MHz); minimum 2.
- `POWER_MAX`, 15: top power value; range 1..15.
- `clk60MHz`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_fire`  in  1  debounced, synchronized fire button level.
- `turn`  in  1  player whose turn it is (`PLAYER_1`/`PLAYER_2`).
- `current_player`  in  1  identity of this board.
- `tx_ready`  in  1  link transmitter can accept a byte.
- `power`  out  4  current/latched power.
- `fire`  out  1  one-cycle launch strobe.
- `tx_data`  out  8  frame: [7:5]=`POWER_HDR`, [4]=`current_player`, [3:0]=`power`.
- `tx_valid`  out  1  frame valid.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CHARGE, LAUNCH, SEND, WAIT_TURN.
- `my_turn` = (`turn == current_player`).
- IDLE: on `btn_fire` rising edge with `my_turn` -> CHARGE; `power` <= 1, tick counter cleared. Edge detector register resets to 1, so a button held through reset release never starts a charge.
- CHARGE: tick counter counts 0..TICK_DIV-1; on wrap `power` increments, saturating at POWER_MAX.
- CHARGE, `btn_fire` low -> LAUNCH; `power` frozen. Release and tick in the same cycle: release wins, no increment.
- CHARGE, `my_turn` drops -> IDLE, `power` <= 0, no `fire`, no frame. Takes priority over release.
- LAUNCH: one cycle, `fire`=1 -> SEND.
- SEND: `tx_valid`=1, `tx_data` stable; on `tx_valid && tx_ready` -> WAIT_TURN. Completes even if `turn` changes.
- WAIT_TURN: hold `power`; when `my_turn` low -> IDLE. Button ignored.
- `power` holds its last value in IDLE until the next charge starts.

## Timing
- Reset: state IDLE, `power`=0, `fire`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, tick counter 0.
- All outputs registered.
- Press sampled at edge N -> `busy`=1, `power`=1 after edge N+1.
- First increment TICK_DIV cycles after CHARGE entry.
- Release sampled at edge M -> `fire`=1 for cycle after M+1, `tx_valid`=1 the cycle after that.
- `tx_valid` deasserts the cycle after the handshake. `tx_ready` high on the first SEND cycle -> `tx_valid` high exactly one cycle.
- `rst_n` low in any state -> immediate return to reset values. An in-flight frame is dropped.

## Configuration
- `POWER_PINGPONG_EN` defined: in CHARGE, power runs 1 -> POWER_MAX, then down to 1, then up again (direction bit, reset to up, cleared on CHARGE entry). A tick at POWER_MAX yields POWER_MAX-1; a tick at 1 while descending yields 2.
- Not defined: power saturates at POWER_MAX, no direction bit.

## Structure
- `variable_pkg` gains:
  - the state enum `charge_state_t`
  - `POWER_HDR` = 3'b101
  - `POWER_W` = 4
- `PLAYER_1`/`PLAYER_2` are already in the package.
- Sub-module `tick_gen` (parameter DIV, inputs `clk60MHz`, `rst_n`, `clr`; output `tick`, one-cycle pulse every DIV cycles after `clr`).

## Test plan
- TICK_DIV=4, `current_player`=0, `turn`=0:
  - press, hold 14 cycles, release -> `power`=1,2,3,4 at cycles 1,5,9,13; `fire` pulses once; `tx_data`=8'hA4 with `tx_ready`=1; `tx_valid` high one cycle.
- Hold for 80 cycles, saturate mode -> `power` stops at 15; frame 8'hAF.
- With `POWER_PINGPONG_EN`, hold 68 cycles -> after reaching 15 `power` reads 14, then 13; released at 13 gives frame 8'hAD.
- Press with `turn`=1 -> stays IDLE, `busy`=0. Press with `turn`=0, then set `turn`=1 mid-charge -> IDLE, `power`=0, no `fire`, no `tx_valid`.
- Release with `tx_ready`=0 for 5 cycles -> `tx_valid` and `tx_data` stable for 6 cycles. Toggle `turn` during the stall: frame still sent, then IDLE.
- Hold `btn_fire`=1 across `rst_n` deassertion -> no charge until release and re-press. Assert `rst_n`=0 during SEND -> `tx_valid` drops immediately, `power`=0.

Source files
------------

// File: rtl/variable_pkg.sv
// Shared game constants and types for the power/launch path.
package variable_pkg;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam int unsigned POWER_W   = 4;
  localparam logic [2:0]  POWER_HDR = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    CHARGE,
    LAUNCH,
    SEND,
    WAIT_TURN
  } charge_state_t;

  // One-byte link frame carrying a launch power.
  typedef struct packed {
    logic [2:0]         hdr;
    logic               player;
    logic [POWER_W-1:0] power;
  } power_frame_t;

  function automatic power_frame_t make_frame(input logic player,
                                              input logic [POWER_W-1:0] pwr);
    power_frame_t f;
    f.hdr    = POWER_HDR;
    f.player = player;
    f.power  = pwr;
    return f;
  endfunction

endpackage

// File: rtl/power_charge_tick_gen.sv
// Free-running divider: one-cycle tick every DIV cycles after clr is released.
module tick_gen #(
  parameter int unsigned DIV = 6_000_000
) (
  input  logic clk60MHz,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/power_charge.sv
// Shot-power generator: ramp while fire is held, launch and send a power frame on release.
// POWER_PINGPONG_EN selects up/down sweeping instead of saturating at POWER_MAX.
module power_charge
  import variable_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 6_000_000,
  parameter int unsigned POWER_MAX = 15
) (
  input  logic               clk60MHz,
  input  logic               rst_n,
  input  logic               btn_fire,
  input  logic               turn,
  input  logic               current_player,
  input  logic               tx_ready,
  output logic [POWER_W-1:0] power,
  output logic               fire,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               busy
);

  localparam logic [POWER_W-1:0] PMAX = POWER_W'(POWER_MAX);

  charge_state_t      state_q, state_d;
  logic [POWER_W-1:0] power_q, power_d;
  power_frame_t       tx_data_q, tx_data_d;
  logic               fire_q, fire_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               btn_s_q, btn_prev_q;
  logic               my_turn, btn_rise, tick, tick_clr;
`ifdef POWER_PINGPONG_EN
  logic               dir_q, dir_d;
`endif

  // Counter only runs while charging, so the first step lands TICK_DIV cycles after entry.
  assign tick_clr = (state_q != CHARGE);

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk60MHz (clk60MHz),
    .rst_n    (rst_n),
    .clr      (tick_clr),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    power_d   = power_q;
    tx_data_d = tx_data_q;
`ifdef POWER_PINGPONG_EN
    dir_d     = dir_q;
`endif
    my_turn   = (turn == current_player);
    btn_rise  = btn_s_q & ~btn_prev_q;

    unique case (state_q)
      IDLE: begin
        if (btn_rise && my_turn) begin
          state_d = CHARGE;
          power_d = POWER_W'(1);
`ifdef POWER_PINGPONG_EN
          dir_d   = 1'b0;
`endif
        end
      end
      CHARGE: begin
        // Losing the turn beats release; release beats a coincident tick.
        if (!my_turn) begin
          state_d = IDLE;
          power_d = '0;
        end else if (!btn_s_q) begin
          state_d = LAUNCH;
        end else if (tick) begin
`ifdef POWER_PINGPONG_EN
          if (!dir_q) begin
            if (power_q >= PMAX) begin
              power_d = PMAX - POWER_W'(1);
              dir_d   = 1'b1;
            end else begin
              power_d = power_q + POWER_W'(1);
            end
          end else begin
            if (power_q <= POWER_W'(1)) begin
              power_d = POWER_W'(2);
              dir_d   = 1'b0;
            end else begin
              power_d = power_q - POWER_W'(1);
            end
          end
`else
          if (power_q < PMAX) begin
            power_d = power_q + POWER_W'(1);
          end
`endif
        end
      end
      LAUNCH: begin
        state_d   = SEND;
        tx_data_d = make_frame(current_player, power_q);
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          state_d = WAIT_TURN;
        end
      end
      WAIT_TURN: begin
        if (!my_turn) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fire_d     = (state_d == LAUNCH);
    tx_valid_d = (state_d == SEND);
    busy_d     = (state_d != IDLE);
  end

  // Edge detector resets high so a button held through reset never starts a charge.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      power_q    <= '0;
      tx_data_q  <= '0;
      fire_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      btn_s_q    <= 1'b1;
      btn_prev_q <= 1'b1;
`ifdef POWER_PINGPONG_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      power_q    <= power_d;
      tx_data_q  <= tx_data_d;
      fire_q     <= fire_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      btn_s_q    <= btn_fire;
      btn_prev_q <= btn_s_q;
`ifdef POWER_PINGPONG_EN
      dir_q      <= dir_d;
`endif
    end
  end

  assign power    = power_q;
  assign fire     = fire_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_power_charge.sv
// Scoreboard bench for power_charge: stimulus queues expectations, a negedge monitor checks them.
module tb_power_charge;
  import variable_pkg::*;

  localparam int DIV  = 4;
  localparam int PMAX = 15;

  localparam int K_POWER = 0;
  localparam int K_BUSY  = 1;
  localparam int K_VALID = 2;
  localparam int K_FIRE  = 3;
  localparam int K_DATA  = 4;
  localparam int K_EMPTY = 5;

  logic       clk60MHz = 1'b0;
  logic       rst_n, btn_fire, turn, current_player, tx_ready;
  logic [3:0] power;
  logic       fire, tx_valid, busy;
  logic [7:0] tx_data;

  int errors = 0;
  int checks = 0;
  bit ready_rand = 1'b0;
  bit ready_val  = 1'b1;

  typedef struct {
    int         kind;
    logic [7:0] exp;
  } chk_t;

  chk_t       now_q[$];
  logic [3:0] exp_fire_q[$];
  logic [7:0] exp_frame_q[$];

  always #5 clk60MHz = ~clk60MHz;

  power_charge #(
    .TICK_DIV  (DIV),
    .POWER_MAX (PMAX)
  ) dut (
    .clk60MHz       (clk60MHz),
    .rst_n          (rst_n),
    .btn_fire       (btn_fire),
    .turn           (turn),
    .current_player (current_player),
    .tx_ready       (tx_ready),
    .power          (power),
    .fire           (fire),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .busy           (busy)
  );

  // Single driver for tx_ready: fixed level or random backpressure.
  always @(posedge clk60MHz) begin
    #1;
    tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Reference: power after a given number of elapsed ticks since charge entry.
  function automatic logic [3:0] model_power(input int ticks);
`ifdef POWER_PINGPONG_EN
    int period = 2 * (PMAX - 1);
    int p = ticks % period;
    return (p <= PMAX - 1) ? 4'(1 + p) : 4'(1 + period - p);
`else
    return (ticks >= PMAX - 1) ? 4'(PMAX) : 4'(1 + ticks);
`endif
  endfunction

  // ---------------- monitor ----------------
  chk_t       c;
  bit         prev_fire, prev_hs, prev_stall;
  logic [7:0] stall_data;
  logic [3:0] ef;
  logic [7:0] efr;

  task automatic report(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk60MHz) begin
    while (now_q.size() > 0) begin
      c = now_q.pop_front();
      case (c.kind)
        K_POWER: report("power", 8'(power), c.exp);
        K_BUSY:  report("busy", 8'(busy), c.exp);
        K_VALID: report("tx_valid", 8'(tx_valid), c.exp);
        K_FIRE:  report("fire", 8'(fire), c.exp);
        K_DATA:  report("tx_data", tx_data, c.exp);
        default: report("pending_expectations", 8'(exp_fire_q.size() + exp_frame_q.size()), c.exp);
      endcase
    end
    if (!rst_n) begin
      exp_frame_q.delete();
      prev_fire  = 1'b0;
      prev_hs    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_fire)  report("valid_after_fire", 8'(tx_valid), 8'd1);
      if (prev_hs)    report("valid_drop_after_handshake", 8'(tx_valid), 8'd0);
      if (prev_stall) report("stall_hold", tx_valid ? tx_data : 8'hxx, stall_data);
      if (fire) begin
        if (exp_fire_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fire_unexpected: got fire=1 power=%0d expected no launch at %0t", power, $time);
        end else begin
          ef = exp_fire_q.pop_front();
          report("launch_power", 8'(power), 8'(ef));
        end
      end
      if (tx_valid && tx_ready) begin
        if (exp_frame_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got %h expected no frame at %0t", tx_data, $time);
        end else begin
          efr = exp_frame_q.pop_front();
          report("frame", tx_data, efr);
        end
      end
      prev_fire  = fire;
      prev_hs    = tx_valid && tx_ready;
      prev_stall = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk60MHz);
    #1;
  endtask

  task automatic expect_now(input int k, input logic [7:0] e);
    now_q.push_back('{kind: k, exp: e});
  endtask

  task automatic charge(input int hold);
    logic [3:0] pw;
    btn_fire = 1'b1;
    for (int j = 1; j <= hold; j++) begin
      step();
      if (j >= 2) begin
        expect_now(K_POWER, 8'(model_power((j - 2) / DIV)));
        expect_now(K_BUSY, 8'd1);
      end
    end
    btn_fire = 1'b0;
    pw = model_power((hold - 1) / DIV);
    exp_fire_q.push_back(pw);
    exp_frame_q.push_back({POWER_HDR, current_player, pw});
  endtask

  task automatic finish_frame();
    int n = 0;
    while ((exp_frame_q.size() != 0 || exp_fire_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      $display("FAIL frame_timeout: got no frame expected %0d pending", exp_frame_q.size());
      $fatal(1);
    end
    turn = PLAYER_2;
    repeat (3) step();
    expect_now(K_BUSY, 8'd0);
    step();
    turn = PLAYER_1;
    repeat (2) step();
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!tx_valid && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) begin
      $display("FAIL valid_timeout: got tx_valid=0 expected 1");
      $fatal(1);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    btn_fire       = 1'b0;
    turn           = PLAYER_1;
    current_player = PLAYER_1;
    step();
    expect_now(K_POWER, 8'd0);
    expect_now(K_FIRE,  8'd0);
    expect_now(K_VALID, 8'd0);
    expect_now(K_DATA,  8'h00);
    expect_now(K_BUSY,  8'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Directed ramps: short, saturating/sweeping, and long sweep.
    charge(14);
    finish_frame();
    charge(80);
    finish_frame();
    charge(68);
    finish_frame();

    // Press while it is the other player's turn.
    turn = PLAYER_2;
    btn_fire = 1'b1;
    repeat (5) begin
      step();
      expect_now(K_BUSY, 8'd0);
    end
    btn_fire = 1'b0;
    repeat (2) step();
    turn = PLAYER_1;
    repeat (2) step();

    // Turn lost mid-charge aborts without launch.
    btn_fire = 1'b1;
    repeat (6) step();
    turn = PLAYER_2;
    repeat (2) step();
    expect_now(K_POWER, 8'd0);
    expect_now(K_BUSY,  8'd0);
    btn_fire = 1'b0;
    repeat (3) step();
    turn = PLAYER_1;
    repeat (2) step();

    // Stalled transmitter with turn change during the stall.
    ready_val = 1'b0;
    repeat (2) step();
    charge(6);
    wait_valid();
    turn = PLAYER_2;
    repeat (4) step();
    expect_now(K_VALID, 8'd1);
    ready_val = 1'b1;
    finish_frame();

    // Button held through reset release must not start a charge.
    rst_n    = 1'b0;
    btn_fire = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (8) begin
      step();
      expect_now(K_BUSY, 8'd0);
    end
    btn_fire = 1'b0;
    repeat (3) step();
    charge(9);
    finish_frame();

    // Reset during SEND drops the frame immediately.
    ready_val = 1'b0;
    repeat (2) step();
    charge(5);
    wait_valid();
    step();
    rst_n = 1'b0;
    #1;
    expect_now(K_VALID, 8'd0);
    expect_now(K_POWER, 8'd0);
    expect_now(K_BUSY,  8'd0);
    expect_now(K_FIRE,  8'd0);
    step();
    rst_n     = 1'b1;
    ready_val = 1'b1;
    repeat (2) step();

    // Randomized holds under random backpressure.
    ready_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      charge(int'($urandom_range(1, 90)));
      finish_frame();
    end
    ready_rand = 1'b0;

    repeat (3) step();
    expect_now(K_EMPTY, 8'd0);
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
